// File: rtl/byte_deser_pkg.sv
// Shared definitions for the byte deserialiser.
//   DATA_W  : frame width in bits
//   CNT_W   : width of the bit counter (holds 0..DATA_W)
//   state_e : deserialiser FSM states
package byte_deser_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/byte_deser_bit_counter.sv
// Saturating up-counter used to count captured bits in a frame.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   clr_i : synchronous clear (back to 0)
//   en_i  : count enable; counting stops at MAX
//   cnt_o : current count
module bit_counter_4
  import byte_deser_pkg::*;
#(
  parameter int unsigned MAX = DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/byte_deser.sv
// Serial-to-parallel byte deserialiser with a Ready handshake.
//   Clk        : system clock
//   Reset      : synchronous active-high reset
//   Start      : opens (or restarts) a frame
//   Shift_En   : bit strobe, Serial_In sampled when high
//   Serial_In  : serial data, LSB first
//   Ready      : downstream accepts Data_Out while Data_Valid is high
//   Clear_Err  : clears the sticky Overrun flag
//   Data_Out   : assembled frame
//   Data_Valid : frame complete, waiting for Ready
//   Busy       : frame being shifted in
//   Bit_Cnt    : bits captured so far (0..DATA_W)
//   Overrun    : sticky flag, Start seen while a frame was waiting
module byte_deser
  import byte_deser_pkg::*;
#(
  parameter int unsigned DATA_W = byte_deser_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Shift_En,
  input  logic              Serial_In,
  input  logic              Ready,
  input  logic              Clear_Err,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Data_Valid,
  output logic              Busy,
  output logic [3:0]        Bit_Cnt,
  output logic              Overrun
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovr_q, ovr_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              ovr_set;
  logic [DATA_W-1:0] shifted;

  assign shifted = {Serial_In, sr_q[DATA_W-1:1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    data_d  = data_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Shift_En is ignored here, even alongside Start
        if (Start) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
          sr_d    = '0;
        end
      end
      SHIFT: begin
        if (Start) begin
          // abort: drop partial bits, restart the count
          cnt_clr = 1'b1;
          sr_d    = '0;
        end else if (Shift_En) begin
          sr_d   = shifted;
          cnt_en = 1'b1;
          if (Bit_Cnt == LAST_BIT) begin
            data_d  = shifted;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (Ready) begin
          cnt_clr = 1'b1;
          sr_d    = '0;
          state_d = Start ? SHIFT : IDLE;
        end else if (Start) begin
          ovr_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // a new overrun wins over a same-cycle clear
    ovr_d = ovr_set | (ovr_q & ~Clear_Err);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  bit_counter_4 #(
    .MAX (DATA_W)
  ) u_bit_counter (
    .clk_i (Clk),
    .rst_i (Reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (Bit_Cnt)
  );

  assign Data_Out   = data_q;
  assign Data_Valid = (state_q == HOLD);
  assign Busy       = (state_q == SHIFT);
  assign Overrun    = ovr_q;

endmodule

// File: tb/tb_byte_deser.sv
module tb_byte_deser;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Shift_En;
  logic       Serial_In;
  logic       Ready;
  logic       Clear_Err;
  logic [7:0] Data_Out;
  logic       Data_Valid;
  logic       Busy;
  logic [3:0] Bit_Cnt;
  logic       Overrun;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0] sb[$];

  typedef struct {
    logic [7:0]  bits;        // bits[i] is sent i-th
    int unsigned hold_cycles; // cycles Ready stays low once the frame is complete
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[5];

  byte_deser #(
    .DATA_W (8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Shift_En   (Shift_En),
    .Serial_In  (Serial_In),
    .Ready      (Ready),
    .Clear_Err  (Clear_Err),
    .Data_Out   (Data_Out),
    .Data_Valid (Data_Valid),
    .Busy       (Busy),
    .Bit_Cnt    (Bit_Cnt),
    .Overrun    (Overrun)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached before end of test");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each accepted frame must match the oldest expected byte.
  always @(negedge Clk) begin
    if (!Reset && Data_Valid && Ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got accepted %0h expected no frame at %0t", Data_Out, $time);
      end else begin
        check("sb_data", Data_Out, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic shift_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      Shift_En  = 1'b1;
      Serial_In = b[i];
      step();
    end
    Shift_En = 1'b0;
  endtask

  // Full 8-bit frame with per-bit counter checks; the expected byte goes to the scoreboard.
  task automatic send_frame(input logic [7:0] b, input logic [7:0] exp);
    sb.push_back(exp);
    for (int unsigned i = 0; i < 8; i++) begin
      Shift_En  = 1'b1;
      Serial_In = b[i];
      step();
      check("bit_cnt", {28'd0, Bit_Cnt}, i + 1);
      if (i < 7) check("busy_shift", {31'd0, Busy}, 1);
    end
    Shift_En = 1'b0;
    check("valid_latency", {31'd0, Data_Valid}, 1);
    check("busy_hold", {31'd0, Busy}, 0);
    check("data_at_valid", {24'd0, Data_Out}, {24'd0, exp});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'd0, Data_Out}, 0);
    check({tag, "_valid"}, {31'd0, Data_Valid}, 0);
    check({tag, "_busy"}, {31'd0, Busy}, 0);
    check({tag, "_cnt"}, {28'd0, Bit_Cnt}, 0);
    check({tag, "_ovr"}, {31'd0, Overrun}, 0);
  endtask

  initial begin
    vecs[0] = '{bits: 8'b0100_1101, hold_cycles: 0, exp_out: 8'h4D};
    vecs[1] = '{bits: 8'hA5,        hold_cycles: 5, exp_out: 8'hA5};
    vecs[2] = '{bits: 8'h00,        hold_cycles: 1, exp_out: 8'h00};
    vecs[3] = '{bits: 8'hFF,        hold_cycles: 0, exp_out: 8'hFF};
    vecs[4] = '{bits: 8'h96,        hold_cycles: 2, exp_out: 8'h96};

    Reset = 1'b1; Start = 1'b0; Shift_En = 1'b0; Serial_In = 1'b0;
    Ready = 1'b0; Clear_Err = 1'b0;
    step();
    step();
    Reset = 1'b0;
    check_reset_outputs("reset");

    // Shift_En alone in IDLE does nothing
    shift_bits(8'hFF, 3);
    check("idle_ignore_cnt", {28'd0, Bit_Cnt}, 0);
    check("idle_ignore_busy", {31'd0, Busy}, 0);

    // Table-driven frames
    for (int unsigned v = 0; v < 5; v++) begin
      Ready = (vecs[v].hold_cycles == 0);
      pulse_start();
      check("start_busy", {31'd0, Busy}, 1);
      check("start_cnt", {28'd0, Bit_Cnt}, 0);
      send_frame(vecs[v].bits, vecs[v].exp_out);
      for (int unsigned k = 0; k < vecs[v].hold_cycles; k++) begin
        step();
        check("hold_valid", {31'd0, Data_Valid}, 1);
        check("hold_data", {24'd0, Data_Out}, {24'd0, vecs[v].exp_out});
        check("hold_cnt", {28'd0, Bit_Cnt}, 8);
      end
      Ready = 1'b1;
      step();
      check("release_valid", {31'd0, Data_Valid}, 0);
      check("release_idle", {31'd0, Busy}, 0);
      check("release_cnt", {28'd0, Bit_Cnt}, 0);
      Ready = 1'b0;
      step();
    end

    // Start with Shift_En in IDLE: that bit is dropped; then abort after 3 bits
    Start = 1'b1; Shift_En = 1'b1; Serial_In = 1'b1;
    step();
    Start = 1'b0; Shift_En = 1'b0;
    check("start_shift_cnt", {28'd0, Bit_Cnt}, 0);
    shift_bits(8'h07, 3);
    check("partial_cnt", {28'd0, Bit_Cnt}, 3);
    Start = 1'b1; Shift_En = 1'b1; Serial_In = 1'b1;
    step();
    Start = 1'b0; Shift_En = 1'b0;
    check("abort_cnt", {28'd0, Bit_Cnt}, 0);
    check("abort_busy", {31'd0, Busy}, 1);
    Ready = 1'b1;
    send_frame(8'h3C, 8'h3C);
    step();
    Ready = 1'b0;
    check("abort_release", {31'd0, Data_Valid}, 0);

    // Overrun in HOLD; Shift_En in HOLD ignored; clear vs. new overrun
    pulse_start();
    send_frame(8'h5A, 8'h5A);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("ovr_set", {31'd0, Overrun}, 1);
    check("ovr_data", {24'd0, Data_Out}, 32'h5A);
    check("ovr_valid", {31'd0, Data_Valid}, 1);
    shift_bits(8'h00, 2);
    check("hold_shift_data", {24'd0, Data_Out}, 32'h5A);
    check("hold_shift_cnt", {28'd0, Bit_Cnt}, 8);
    check("ovr_sticky", {31'd0, Overrun}, 1);
    Clear_Err = 1'b1;
    step();
    Clear_Err = 1'b0;
    check("ovr_clear", {31'd0, Overrun}, 0);
    Clear_Err = 1'b1; Start = 1'b1;
    step();
    Clear_Err = 1'b0; Start = 1'b0;
    check("ovr_clear_vs_set", {31'd0, Overrun}, 1);
    Clear_Err = 1'b1;
    step();
    Clear_Err = 1'b0;
    check("ovr_clear2", {31'd0, Overrun}, 0);
    Ready = 1'b1;
    step();
    Ready = 1'b0;

    // Reset after 5 bits, then a full 0xFF frame
    pulse_start();
    shift_bits(8'h1F, 5);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_reset_outputs("rst_mid");
    Ready = 1'b1;
    pulse_start();
    send_frame(8'hFF, 8'hFF);
    step();
    Ready = 1'b0;

    // Reset while a frame is waiting in HOLD: it is never delivered
    pulse_start();
    send_frame(8'h6E, 8'h6E);
    Start = 1'b1;
    step();
    Start = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    void'(sb.pop_back());
    check_reset_outputs("rst_hold");

    // Back-to-back: Ready and Start together in HOLD
    pulse_start();
    send_frame(8'h42, 8'h42);
    step();
    Ready = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    check("b2b_busy", {31'd0, Busy}, 1);
    check("b2b_valid", {31'd0, Data_Valid}, 0);
    check("b2b_cnt", {28'd0, Bit_Cnt}, 0);
    send_frame(8'h81, 8'h81);
    step();
    Ready = 1'b0;
    check("b2b_end", {31'd0, Data_Valid}, 0);

    step();
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
